// File: rtl/or_logic_unit_acc_pkg.sv
// Shared op codes, FSM encodings and the frame-op to reduction-op mapping.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package or_logic_unit_acc_pkg;

    typedef enum logic [1:0] {
        OP_AND = 2'b00,
        OP_OR  = 2'b01,
        OP_XOR = 2'b10,
        OP_NOR = 2'b11
    } op_e;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_ACCUM = 1'b1
    } state_e;

    // A NOR frame reduces with OR and inverts only the emitted value.
    function automatic op_e reduceOp(input op_e frameOp);
        return (frameOp == OP_NOR) ? OP_OR : frameOp;
    endfunction

endpackage

// File: rtl/or_logic_unit_acc_logic_op.sv
// Bitwise AND/OR/XOR/NOR of two WIDTH-bit operands.
// Latency: combinational.
// Backpressure: none (pure function).
module logic_op
    import or_logic_unit_acc_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] y,
    input  op_e              op,
    output logic [WIDTH-1:0] z
);

    always_comb begin
        z = '0;
        case (op)
            OP_AND:  z = x & y;
            OP_OR:   z = x | y;
            OP_XOR:  z = x ^ y;
            OP_NOR:  z = ~(x | y);
            default: z = '0;
        endcase
    end

endmodule

// File: rtl/or_logic_unit_acc.sv
// Bitwise logic unit with direct mode and multi-beat accumulate frames.
// Latency: 1 cycle from the emitting beat to out_valid.
// Backpressure: in_ready = !out_valid || out_ready; output held while stalled.
module or_logic_unit_acc
    import or_logic_unit_acc_pkg::*;
#(
    parameter int WIDTH = 4,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       op,
    input  logic             acc_mode,
    input  logic             in_last,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic [CNT_W-1:0] beats
);

    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    state_e           state;
    state_e           stateNext;
    logic [WIDTH-1:0] acc;
    logic [WIDTH-1:0] accNext;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cntNext;
    op_e              frameOp;
    op_e              frameOpNext;
    op_e              beatOp;
    op_e              reduceSel;
    logic             beatFire;
    logic             emit;
    logic [WIDTH-1:0] directZ;
    logic [WIDTH-1:0] reduceZ;
    logic [WIDTH-1:0] emitResult;
    logic [CNT_W-1:0] emitBeats;

    assign beatOp    = op_e'(op);
    assign reduceSel = reduceOp(frameOp);
    assign in_ready  = !out_valid || out_ready;
    assign beatFire  = in_valid && in_ready;

    logic_op #(.WIDTH(WIDTH)) uDirect (
        .x  (A),
        .y  (B),
        .op (beatOp),
        .z  (directZ)
    );

    logic_op #(.WIDTH(WIDTH)) uReduce (
        .x  (acc),
        .y  (A),
        .op (reduceSel),
        .z  (reduceZ)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= stateNext;
        end
    end

    always_comb begin
        stateNext = state;
        if (beatFire) begin
            case (state)
                ST_IDLE:  if (acc_mode && !in_last) stateNext = ST_ACCUM;
                ST_ACCUM: if (in_last) stateNext = ST_IDLE;
                default:  stateNext = ST_IDLE;
            endcase
        end
    end

    // Frame bookkeeping and the value to emit for the beat being accepted.
    always_comb begin
        accNext     = acc;
        cntNext     = cnt;
        frameOpNext = frameOp;
        emit        = 1'b0;
        emitResult  = directZ;
        emitBeats   = CNT_ONE;
        if (beatFire) begin
            case (state)
                ST_IDLE: begin
                    if (acc_mode) begin
                        accNext     = A;
                        cntNext     = CNT_ONE;
                        frameOpNext = beatOp;
                        emit        = in_last;
                        emitResult  = (beatOp == OP_NOR) ? ~A : A;
                    end else begin
                        emit = 1'b1;
                    end
                end
                ST_ACCUM: begin
                    accNext    = reduceZ;
                    cntNext    = (cnt == CNT_MAX) ? cnt : cnt + CNT_ONE;
                    emit       = in_last;
                    emitResult = (frameOp == OP_NOR) ? ~reduceZ : reduceZ;
                    emitBeats  = cntNext;
                end
                default: emit = 1'b0;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            acc     <= '0;
            cnt     <= '0;
            frameOp <= OP_AND;
        end else begin
            acc     <= accNext;
            cnt     <= cntNext;
            frameOp <= frameOpNext;
        end
    end

    // Emitting while the consumer takes the old result keeps out_valid high.
    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid <= 1'b0;
            result    <= '0;
            zero      <= 1'b1;
            beats     <= '0;
        end else if (emit) begin
            out_valid <= 1'b1;
            result    <= emitResult;
            zero      <= (emitResult == '0);
            beats     <= emitBeats;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule
